// File: rtl/imem_loader.sv
// Boot loader for the instruction memory: parses a framed byte stream, writes
// little-endian words from address 0 and releases the core once the checksum matches.
module imem_loader #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_vld,
    input  logic [7:0]        byte_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN0 = 3'd1;
    localparam logic [2:0] S_LEN1 = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_CHK  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;
    localparam logic [7:0]  SYNC = 8'hA5;

    logic [2:0]       state, state_nxt;
    logic [15:0]      len;
    logic [16:0]      word_cnt;
    logic [1:0]       byte_idx;
    logic [7:0]       sum;
    logic [23:0]      word_lo;
    logic [TMR_W-1:0] tmr;
    logic             in_frame;
    logic             timeout_hit;
    logic [15:0]      len_in;

    assign in_frame    = (state == S_LEN0) || (state == S_LEN1) ||
                         (state == S_DATA) || (state == S_CHK);
    // The counter is cleared by any accepted byte, so expiry only counts silent cycles.
    assign timeout_hit = in_frame && !byte_vld && (tmr == TMR_W'(TIMEOUT - 1));
    assign len_in      = {byte_data, len[7:0]};

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (byte_vld && byte_data == SYNC) state_nxt = S_LEN0;
            S_LEN0: if (byte_vld) state_nxt = S_LEN1;
            S_LEN1: begin
                if (byte_vld) begin
                    if ({1'b0, len_in} > MAX_WORDS) state_nxt = S_ERR;
                    else if (len_in == 16'd0)       state_nxt = S_CHK;
                    else                            state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (byte_vld && byte_idx == 2'd3 && (word_cnt + 17'd1) == {1'b0, len})
                    state_nxt = S_CHK;
            end
            S_CHK: if (byte_vld) state_nxt = (byte_data == sum) ? S_DONE : S_ERR;
            S_DONE, S_ERR: if (byte_vld && byte_data == SYNC) state_nxt = S_LEN0;
            default: state_nxt = S_IDLE;
        endcase
        if (timeout_hit) state_nxt = S_ERR;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            len      <= '0;
            word_cnt <= '0;
            byte_idx <= '0;
            sum      <= '0;
            word_lo  <= '0;
            tmr      <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            core_rst <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            wr_en    <= 1'b0;
            busy     <= (state_nxt == S_LEN0) || (state_nxt == S_LEN1) ||
                        (state_nxt == S_DATA) || (state_nxt == S_CHK);
            done     <= (state_nxt == S_DONE);
            err      <= (state_nxt == S_ERR);
            core_rst <= (state_nxt != S_DONE);

            if (in_frame && !byte_vld) tmr <= tmr + 1'b1;
            else                       tmr <= '0;

            case (state)
                S_LEN0: if (byte_vld) len[7:0] <= byte_data;
                S_LEN1: begin
                    if (byte_vld) begin
                        len[15:8] <= byte_data;
                        word_cnt  <= '0;
                        byte_idx  <= '0;
                        sum       <= '0;
                    end
                end
                S_DATA: begin
                    if (byte_vld) begin
                        sum      <= sum + byte_data;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_lo[7:0]   <= byte_data;
                            2'd1: word_lo[15:8]  <= byte_data;
                            2'd2: word_lo[23:16] <= byte_data;
                            default: begin
                                wr_en    <= 1'b1;
                                wr_addr  <= word_cnt[ADDR_W-1:0];
                                wr_data  <= {byte_data, word_lo};
                                word_cnt <= word_cnt + 17'd1;
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
